// File: rtl/regfile_2w2r.sv
// regfile_2w2r: parameterised register file with two write ports and two
// combinational read ports, a per-register busy scoreboard for outstanding
// loads, and a registered write-collision flag.
//
// Ports:
//   clk, reset          rising-edge clock; async active-high reset
//   wa_en/addr/data     ALU result write port (wins on same-index collision)
//   wb_en/addr/data     load writeback port; also clears busy[wb_addr]
//   rsv_en/addr         mark a register busy when a load issues
//   ra_*/rb_*           read ports: index in, data + busy out (combinational)
//   busy_vec            scoreboard, bit i = register i busy
//   wr_collide          one-cycle pulse after a wa/wb same-index write

// One read port: stored value, optional forwarding, optional zero r0.
module regfile_2w2r_rdport #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic [ADDR_W-1:0]                   addr_i,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]  regs_i,
  input  logic [(1<<ADDR_W)-1:0]              busy_i,
  input  logic                                wa_en_i,
  input  logic [ADDR_W-1:0]                   wa_addr_i,
  input  logic [DATA_W-1:0]                   wa_data_i,
  input  logic                                wb_en_i,
  input  logic [ADDR_W-1:0]                   wb_addr_i,
  input  logic [DATA_W-1:0]                   wb_data_i,
  output logic [DATA_W-1:0]                   data_o,
  output logic                                busy_o
);
  logic wa_hit, wb_hit;

  assign wa_hit = wa_en_i && (wa_addr_i == addr_i);
  assign wb_hit = wb_en_i && (wb_addr_i == addr_i);

  always_comb begin
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
    if (BYPASS != 0) begin
      // ALU result is the younger instruction, so it forwards ahead of wb.
      if (wa_hit)      data_o = wa_data_i;
      else if (wb_hit) data_o = wb_data_i;
      // Load data is being forwarded right now, so the consumer need not stall.
      if (wb_hit)      busy_o = 1'b0;
    end
    if ((ZERO_R0 != 0) && (addr_i == '0)) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end
endmodule

module regfile_2w2r #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wa_en,
  input  logic [ADDR_W-1:0]          wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic [ADDR_W-1:0]          ra_addr,
  output logic [DATA_W-1:0]          ra_data,
  output logic                       ra_busy,
  input  logic [ADDR_W-1:0]          rb_addr,
  output logic [DATA_W-1:0]          rb_data,
  output logic                       rb_busy,
  output logic [(1<<ADDR_W)-1:0]     busy_vec,
  output logic                       wr_collide
);
  localparam int NREG = 1 << ADDR_W;
  localparam int NRD  = 2;

  logic [NREG-1:0][DATA_W-1:0] regs_q;
  logic [NREG-1:0]             busy_q, busy_d;
  logic                        collide_q, collide_d;
  logic                        wa_ok, wb_ok;

  // Writes to r0 are dropped entirely when it is hardwired to zero.
  assign wa_ok = wa_en && !((ZERO_R0 != 0) && (wa_addr == '0));
  assign wb_ok = wb_en && !((ZERO_R0 != 0) && (wb_addr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wa_ok && (wa_addr == ADDR_W'(i)))      regs_q[i] <= wa_data;
        else if (wb_ok && (wb_addr == ADDR_W'(i))) regs_q[i] <= wb_data;
      end
    end
  end

  // Clear-then-set ordering makes a same-cycle reserve win over writeback.
  always_comb begin
    busy_d = busy_q;
    if (wb_en)  busy_d[wb_addr]  = 1'b0;
    if (rsv_en) busy_d[rsv_addr] = 1'b1;
    if (ZERO_R0 != 0) busy_d[0] = 1'b0;
  end

  // Collision is reported even for r0, where neither write lands.
  assign collide_d = wa_en && wb_en && (wa_addr == wb_addr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q    <= '0;
      collide_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  assign busy_vec   = busy_q;
  assign wr_collide = collide_q;

  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_busy;

  assign rd_addr = {rb_addr, ra_addr};
  assign ra_data = rd_data[0];
  assign rb_data = rd_data[1];
  assign ra_busy = rd_busy[0];
  assign rb_busy = rd_busy[1];

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_2w2r_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0), .BYPASS(BYPASS)
    ) u_rd (
      .addr_i   (rd_addr[p]),
      .regs_i   (regs_q),
      .busy_i   (busy_q),
      .wa_en_i  (wa_en),
      .wa_addr_i(wa_addr),
      .wa_data_i(wa_data),
      .wb_en_i  (wb_en),
      .wb_addr_i(wb_addr),
      .wb_data_i(wb_data),
      .data_o   (rd_data[p]),
      .busy_o   (rd_busy[p])
    );
  end
endmodule
